// File: rtl/trc_i2c_slave.sv
// I2C slave front end for the TRC register file: filters SCL/SDA, decodes
// START/STOP and bytes, and issues register write strobes / read fetches.
module trc_i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h30,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_drive_low,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data,
    output logic       wr_stb,
    input  logic [7:0] rd_data,
    output logic       rd_stb,
    output logic       busy
);
    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] ADDR     = 4'd1;
    localparam logic [3:0] ACK_ADDR = 4'd2;
    localparam logic [3:0] REG      = 4'd3;
    localparam logic [3:0] ACK_REG  = 4'd4;
    localparam logic [3:0] WR_DATA  = 4'd5;
    localparam logic [3:0] ACK_WR   = 4'd6;
    localparam logic [3:0] RD_LOAD  = 4'd7;
    localparam logic [3:0] RD_DATA  = 4'd8;
    localparam logic [3:0] RD_ACK   = 4'd9;
    localparam logic [3:0] IGNORE   = 4'd10;

    localparam logic [2:0] FLT_MAX = 3'(FILTER_LEN - 1);

    // line index 0 = SCL, 1 = SDA
    logic [1:0]      raw_pin, sync1, sync2, filt, filt_d;
    logic [1:0][2:0] fcnt;

    assign raw_pin = {sda_in, scl_in};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 2'b11;
            sync2  <= 2'b11;
            filt   <= 2'b11;
            filt_d <= 2'b11;
            fcnt   <= '0;
        end else begin
            sync1  <= raw_pin;
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FLT_MAX) begin
                    filt[i] <= sync2[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 3'd1;
                end
            end
        end
    end

    logic scl_rise, scl_fall, start_c, stop_c;
    assign scl_rise = filt[0] & ~filt_d[0];
    assign scl_fall = ~filt[0] & filt_d[0];
    assign start_c  = ~filt[1] & filt_d[1] & filt[0];
    assign stop_c   = filt[1] & ~filt_d[1] & filt[0];

    logic [3:0] state;
    logic [2:0] bit_cnt;
    logic       got_bit, rw, mack, byte_done;
    logic [7:0] shift, tx;

    // got_bit makes the SCL fall that follows START not count as a bit
    assign byte_done = scl_fall & got_bit & (bit_cnt == 3'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= 3'd7;
            got_bit       <= 1'b0;
            rw            <= 1'b0;
            mack          <= 1'b1;
            shift         <= 8'h00;
            tx            <= 8'h00;
            sda_drive_low <= 1'b0;
            reg_addr      <= 8'h00;
            wr_data       <= 8'h00;
            wr_stb        <= 1'b0;
            rd_stb        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
            if (scl_rise) begin
                shift   <= {shift[6:0], filt[1]};
                got_bit <= 1'b1;
            end
            if (start_c) begin
                state         <= ADDR;
                bit_cnt       <= 3'd7;
                got_bit       <= 1'b0;
                sda_drive_low <= 1'b0;
            end else if (stop_c) begin
                state         <= IDLE;
                sda_drive_low <= 1'b0;
                busy          <= 1'b0;
            end else begin
                if (scl_fall) begin
                    got_bit <= 1'b0;
                    if (got_bit && bit_cnt != 3'd0)
                        bit_cnt <= bit_cnt - 3'd1;
                end
                case (state)
                    ADDR: if (byte_done) begin
                        if (shift[7:1] == SLAVE_ADDR) begin
                            state         <= ACK_ADDR;
                            busy          <= 1'b1;
                            rw            <= shift[0];
                            sda_drive_low <= 1'b1;
                        end else begin
                            state <= IGNORE;
                            busy  <= 1'b0;
                        end
                    end
                    ACK_ADDR: if (scl_fall) begin
                        sda_drive_low <= 1'b0;
                        bit_cnt       <= 3'd7;
                        state         <= rw ? RD_LOAD : REG;
                    end
                    REG: if (byte_done) begin
                        reg_addr      <= shift;
                        sda_drive_low <= 1'b1;
                        state         <= ACK_REG;
                    end
                    ACK_REG: if (scl_fall) begin
                        sda_drive_low <= 1'b0;
                        bit_cnt       <= 3'd7;
                        state         <= WR_DATA;
                    end
                    WR_DATA: if (byte_done) begin
                        wr_data       <= shift;
                        wr_stb        <= 1'b1;
                        sda_drive_low <= 1'b1;
                        state         <= ACK_WR;
                    end
                    ACK_WR: if (scl_fall) begin
                        sda_drive_low <= 1'b0;
                        bit_cnt       <= 3'd7;
                        reg_addr      <= reg_addr + 8'd1;
                        state         <= WR_DATA;
                    end
                    RD_LOAD: begin
                        tx            <= rd_data;
                        rd_stb        <= 1'b1;
                        sda_drive_low <= ~rd_data[7];
                        bit_cnt       <= 3'd7;
                        got_bit       <= 1'b0;
                        state         <= RD_DATA;
                    end
                    RD_DATA: if (scl_fall && got_bit) begin
                        if (bit_cnt == 3'd0) begin
                            sda_drive_low <= 1'b0;
                            state         <= RD_ACK;
                        end else begin
                            tx            <= {tx[6:0], 1'b0};
                            sda_drive_low <= ~tx[6];
                        end
                    end
                    RD_ACK: begin
                        if (scl_rise)
                            mack <= filt[1];
                        if (scl_fall && got_bit) begin
                            if (mack) begin
                                state <= IGNORE;
                            end else begin
                                reg_addr <= reg_addr + 8'd1;
                                state    <= RD_LOAD;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trc_i2c_slave.sv
// Bench for trc_i2c_slave: bit-banged I2C master, byte-level transaction
// model with strobe scoreboards, and literal end-of-scenario expectations.
module tb_trc_i2c_slave;
    localparam int Q = 10;  // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_in, sda_in, sda_drive_low, wr_stb, rd_stb, busy;
    logic [7:0] reg_addr, wr_data, rd_data;
    logic       m_scl = 1'b1, m_sda = 1'b1;
    logic [7:0] mem [256];

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    assign scl_in  = m_scl;
    assign sda_in  = m_sda & ~sda_drive_low;
    assign rd_data = mem[reg_addr];

    trc_i2c_slave #(.SLAVE_ADDR(7'h30), .FILTER_LEN(3)) dut (
        .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in),
        .sda_drive_low(sda_drive_low), .reg_addr(reg_addr), .wr_data(wr_data),
        .wr_stb(wr_stb), .rd_data(rd_data), .rd_stb(rd_stb), .busy(busy)
    );

    // byte-level model of the register interface
    int          m_phase = 0;  // 0 none, 1 expect pointer, 2 write data, 3 read
    logic [7:0]  m_ptr = 8'h00;
    bit          m_sel = 1'b0;
    logic [15:0] exp_wr [$];
    logic [7:0]  exp_rd [$];
    int          wr_cnt = 0, rd_cnt = 0;
    bit          any_drive = 1'b0, any_busy = 1'b0, chk_on = 1'b0;
    logic [7:0]  last_wr_addr = 8'h00, last_wr_data = 8'h00;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
    endtask

    function automatic logic model_tx(input logic [7:0] b, input bit first);
        if (first) begin
            if (b[7:1] == 7'h30) begin
                m_sel   = 1'b1;
                m_phase = b[0] ? 3 : 1;
                if (b[0]) exp_rd.push_back(m_ptr);
                return 1'b0;
            end
            m_sel   = 1'b0;
            m_phase = 0;
            return 1'b1;
        end
        case (m_phase)
            1: begin m_ptr = b; m_phase = 2; return 1'b0; end
            2: begin exp_wr.push_back({m_ptr, b}); m_ptr = m_ptr + 8'd1; return 1'b0; end
            default: return 1'b1;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset && chk_on) begin
            if (sda_drive_low) any_drive = 1'b1;
            if (busy) any_busy = 1'b1;
            total++;
            if (sda_drive_low && !m_sel) begin
                bad++;
                $display("FAIL drive_unselected: sda_drive_low=1 while not addressed");
            end
            if (wr_stb || rd_stb) begin
                total++;
                if (!busy || (wr_stb && rd_stb)) begin
                    bad++;
                    $display("FAIL strobe_rule: wr=%b rd=%b busy=%b", wr_stb, rd_stb, busy);
                end
            end
            if (wr_stb) begin
                logic [15:0] e;
                wr_cnt++;
                last_wr_addr = reg_addr;
                last_wr_data = wr_data;
                if (exp_wr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected: addr %h data %h want none", reg_addr, wr_data);
                end else begin
                    e = exp_wr.pop_front();
                    check8("wr_addr", reg_addr, e[15:8]);
                    check8("wr_data", wr_data, e[7:0]);
                end
            end
            if (rd_stb) begin
                rd_cnt++;
                if (exp_rd.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: addr %h want none", reg_addr);
                end else begin
                    check8("rd_addr", reg_addr, exp_rd.pop_front());
                end
            end
        end
    end

    task automatic bit_io(input logic b, output logic s, input bit glitch);
        m_sda = b;
        wclk(Q);
        m_scl = 1'b1;
        if (glitch) begin
            wclk(8); m_scl = 1'b0;
            wclk(1); m_scl = 1'b1;
            wclk(1);
            #1 s = sda_in;
            wclk(3); m_sda = ~b;
            wclk(2); m_sda = b;
            wclk(5);
        end else begin
            wclk(Q);
            #1 s = sda_in;
            wclk(Q);
        end
        m_scl = 1'b0;
        wclk(Q);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wclk(Q);
        m_scl = 1'b1; wclk(2*Q);
        m_sda = 1'b0; wclk(2*Q);
        m_scl = 1'b0; wclk(Q);
    endtask

    task automatic i2c_stop();
        m_sel = 1'b0;
        m_sda = 1'b0; wclk(Q);
        m_scl = 1'b1; wclk(2*Q);
        m_sda = 1'b1; wclk(4*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit first, input int glitch_bit);
        logic s, exp_ack;
        exp_ack = model_tx(b, first);
        for (int i = 7; i >= 0; i--) bit_io(b[i], s, i == glitch_bit);
        bit_io(1'b1, s, 1'b0);
        check8("ack", {7'b0, s}, {7'b0, exp_ack});
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) bit_io(1'b1, d[i], 1'b0);
        if (!mack) begin
            m_ptr = m_ptr + 8'd1;
            exp_rd.push_back(m_ptr);
        end else begin
            m_phase = 0;
        end
        bit_io(mack, s, 1'b0);
    endtask

    task automatic scenario1();
        int w0;
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h60, 1, -1);
        send_byte(8'h05, 0, -1);
        send_byte(8'hA5, 0, -1);
        i2c_stop();
        check8("s1_wr_count", 8'(wr_cnt - w0), 8'd1);
        check8("s1_wr_addr", last_wr_addr, 8'h05);
        check8("s1_wr_data", last_wr_data, 8'hA5);
        check8("s1_reg_addr", reg_addr, 8'h06);
        check8("s1_busy", {7'b0, busy}, 8'h00);
    endtask

    initial begin
        int w0, r0;
        logic [7:0] d0, d1, e0, e1;
        logic s;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[8'h10] = 8'h3C;
        mem[8'h11] = 8'hC3;

        wclk(4);
        #1;
        check8("rst_sda", {7'b0, sda_drive_low}, 8'h00);
        check8("rst_reg_addr", reg_addr, 8'h00);
        check8("rst_wr_data", wr_data, 8'h00);
        check8("rst_wr_stb", {7'b0, wr_stb}, 8'h00);
        check8("rst_rd_stb", {7'b0, rd_stb}, 8'h00);
        check8("rst_busy", {7'b0, busy}, 8'h00);
        reset = 1'b0;
        chk_on = 1'b1;
        wclk(4*Q);

        scenario1();

        // burst write across the pointer wrap
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h60, 1, -1);
        send_byte(8'hFE, 0, -1);
        send_byte(8'h11, 0, -1);
        send_byte(8'h22, 0, -1);
        send_byte(8'h33, 0, -1);
        i2c_stop();
        check8("s2_wr_count", 8'(wr_cnt - w0), 8'd3);
        check8("s2_last_addr", last_wr_addr, 8'h00);
        check8("s2_last_data", last_wr_data, 8'h33);
        check8("s2_reg_addr", reg_addr, 8'h01);

        // pointer set, repeated START, two-byte read
        w0 = wr_cnt; r0 = rd_cnt;
        i2c_start();
        send_byte(8'h60, 1, -1);
        send_byte(8'h10, 0, -1);
        i2c_start();
        send_byte(8'h61, 1, -1);
        e0 = mem[m_ptr];
        recv_byte(1'b0, d0);
        e1 = mem[m_ptr];
        recv_byte(1'b1, d1);
        i2c_stop();
        check8("s3_byte0_model", d0, e0);
        check8("s3_byte1_model", d1, e1);
        check8("s3_byte0", d0, 8'h3C);
        check8("s3_byte1", d1, 8'hC3);
        check8("s3_rd_count", 8'(rd_cnt - r0), 8'd2);
        check8("s3_wr_count", 8'(wr_cnt - w0), 8'd0);
        check8("s3_reg_addr", reg_addr, m_ptr);
        check8("s3_reg_addr_lit", reg_addr, 8'h11);
        check8("s3_busy", {7'b0, busy}, 8'h00);

        // address mismatch
        w0 = wr_cnt; r0 = rd_cnt;
        any_drive = 1'b0; any_busy = 1'b0;
        i2c_start();
        send_byte(8'h62, 1, -1);
        send_byte(8'h55, 0, -1);
        i2c_stop();
        check8("s4_drive", {7'b0, any_drive}, 8'h00);
        check8("s4_busy", {7'b0, any_busy}, 8'h00);
        check8("s4_strobes", 8'(wr_cnt - w0 + rd_cnt - r0), 8'd0);

        // glitches on SCL and SDA during data bit 6 (a '1')
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h60, 1, -1);
        send_byte(8'h20, 0, -1);
        send_byte(8'h5A, 0, 6);
        i2c_stop();
        check8("s5_wr_count", 8'(wr_cnt - w0), 8'd1);
        check8("s5_wr_addr", last_wr_addr, 8'h20);
        check8("s5_wr_data", last_wr_data, 8'h5A);
        check8("s5_reg_addr", reg_addr, 8'h21);

        // reset in the SCL-low phase of data bit 4
        w0 = wr_cnt;
        i2c_start();
        send_byte(8'h60, 1, -1);
        send_byte(8'h40, 0, -1);
        for (int i = 7; i >= 5; i--) bit_io(d0[0] | 1'b1 & (8'hA5 >> i), s, 1'b0);
        m_sda = 1'b0;
        wclk(3);
        reset = 1'b1;
        m_ptr = 8'h00; m_phase = 0; m_sel = 1'b0;
        exp_wr.delete(); exp_rd.delete();
        @(posedge clk);
        #1;
        check8("s6_sda", {7'b0, sda_drive_low}, 8'h00);
        check8("s6_reg_addr", reg_addr, 8'h00);
        check8("s6_wr_data", wr_data, 8'h00);
        check8("s6_strobes", {6'b0, wr_stb, rd_stb}, 8'h00);
        check8("s6_busy", {7'b0, busy}, 8'h00);
        reset = 1'b0;
        wclk(Q);
        m_scl = 1'b1; wclk(2*Q);
        m_scl = 1'b0; wclk(Q);
        for (int i = 3; i >= 0; i--) bit_io(1'((8'hA5 >> i) & 8'h01), s, 1'b0);
        bit_io(1'b1, s, 1'b0);
        check8("s6_no_ack", {7'b0, s}, 8'h01);
        i2c_stop();
        check8("s6_wr_count", 8'(wr_cnt - w0), 8'd0);

        scenario1();

        check8("final_wr_queue", 8'(exp_wr.size()), 8'd0);
        check8("final_rd_queue", 8'(exp_rd.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trc_i2c_slave.md
Name: trc_i2c_slave

Overview:
I2C slave front end of the TRC. It receives host transactions on SCL/SDA and converts them into single-cycle register write strobes and read-data fetches for the TRC register file. The register file drives the relay, TAP-driver and VCCIO-adjust outputs. The block sits directly upstream of that register logic and runs on the main oscillator clock.

Parameters:
SLAVE_ADDR, 7'h30, 7-bit I2C device address this block acknowledges.
FILTER_LEN, 3, number of consecutive identical synchronized samples required before a filtered SCL/SDA level changes (range 1..7).

Ports:
clk  input  1  main clock (oscillator domain); all logic on rising edge.
reset  input  1  synchronous, active-high reset.
scl_in  input  1  raw SCL pin level (asynchronous).
sda_in  input  1  raw SDA pin level (asynchronous).
sda_drive_low  output  1  1 = pull SDA low (open-drain enable); 0 = release.
reg_addr  output  8  current register pointer.
wr_data  output  8  write data; valid while wr_stb=1.
wr_stb  output  1  one-cycle register write strobe.
rd_data  input  8  register file content at reg_addr; combinational from reg_addr.
rd_stb  output  1  one-cycle pulse when rd_data is captured for transmit.
busy  output  1  1 from an address match until STOP or mismatch-idle.

Behaviour:
- Reset values: sda_drive_low=0, reg_addr=8'h00, wr_data=8'h00, wr_stb=0, rd_stb=0, busy=0, state=IDLE. Filtered SCL and SDA both reset to 1.
- Input conditioning:
  - 2-FF synchronizer per line, then a FILTER_LEN glitch filter.
  - All edge and condition detection uses filtered levels only.
  - Edge pulses scl_rise/scl_fall are one clk wide.
- START: filtered SDA falls while filtered SCL=1. STOP: filtered SDA rises while SCL=1.
  - START and STOP override every state.
  - START (including repeated START) goes to ADDR with bit counter=7.
  - STOP goes to IDLE, releases SDA and clears busy.
- Bit handling:
  - Shift register captures SDA on scl_rise, MSB first.
  - The bit counter decrements on scl_fall.
  - A byte completes on the scl_fall after the 8th scl_rise.
- States:
  - IDLE: wait for START.
  - ADDR: receive 8 bits. If byte[7:1]==SLAVE_ADDR, go to ACK_ADDR and set busy. Otherwise go to IGNORE (SDA released until START/STOP).
  - ACK_ADDR: drive SDA low from byte-completion scl_fall to the next scl_fall. Then R/W=0 goes to REG; R/W=1 goes to RD_LOAD.
  - REG: receive pointer byte, then go to ACK_REG. reg_addr is loaded at byte completion.
  - ACK_REG: ACK as above, then go to WR_DATA.
  - WR_DATA: receive data byte. At byte completion, wr_data is loaded and wr_stb pulses for exactly one clk; then go to ACK_WR.
  - ACK_WR: ACK. On the ACK-ending scl_fall, reg_addr increments (8'hFF wraps to 8'h00), then return to WR_DATA.
  - RD_LOAD: one clk. Capture rd_data into the transmit register, pulse rd_stb, go to RD_DATA.
  - RD_DATA: output the transmit register MSB first. sda_drive_low = ~bit, updated on each scl_fall; the first bit is driven immediately on entry (SCL is low). After 8 bits, release SDA on the scl_fall and go to RD_ACK.
  - RD_ACK: sample SDA on scl_rise.
    - Master ACK (0): reg_addr increments (wrapping) on the next scl_fall, then go to RD_LOAD.
    - Master NACK (1): go to IGNORE.
- Write followed by repeated START with R/W=1 reads from the pointer last set or incremented.
- The pointer persists across transactions until reset.
- wr_stb and rd_stb never assert in the same cycle, and never assert outside busy.
- Reset mid-transaction:
  - Returns to IDLE with SDA released on the next clk.
  - A subsequent bus activity without a fresh START is ignored.
- Clock ratio: valid for f_clk >= 20 x f_SCL with FILTER_LEN=3; operation below that ratio is undefined.

Test Plan:
1. Write: START, 0x60 (addr 0x30, W), 0x05, 0xA5, STOP -> three ACKs; exactly one wr_stb with reg_addr=0x05, wr_data=0xA5; reg_addr=0x06 after; busy=0 after STOP.
2. Burst write with wrap: pointer 0xFE, data 0x11, 0x22, 0x33 -> wr_stb at addresses 0xFE, 0xFF, 0x00 with matching data; final reg_addr=0x01.
3. Pointer set + repeated START read: 0x60, 0x10, rSTART, 0x61; register file returns 0x3C@0x10 and 0xC3@0x11. Master ACKs the first byte and NACKs the second -> SDA bits 0x3C then 0xC3; two rd_stb pulses; no wr_stb.
4. Address mismatch: START, 0x62, 0x55, STOP -> sda_drive_low stays 0 throughout; no strobes; busy stays 0.
5. Glitch rejection: 1-clk low pulse on SCL during a data bit plus a 2-clk SDA pulse while SCL high (FILTER_LEN=3) -> no extra bit, no false START/STOP; byte received correctly.
6. Reset mid-write: assert reset for 1 clk during bit 4 of the data byte -> all outputs reach their reset values next cycle. The remaining bits and STOP produce no wr_stb. The next full transaction from scenario 1 succeeds.
